// File: rtl/nec_frame_receiver.sv
// NEC IR frame receiver: times mark/space durations of the demodulated IR line
// and assembles 32-bit frames, flagging repeat codes, malformed frames and timeouts.
module nec_frame_receiver #(
  parameter int UNIT_CYCLES = 28125,
  parameter int CNT_WIDTH   = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ir,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  output logic        o_repeat,
  output logic        o_error
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t HALF_U      = cnt_t'(UNIT_CYCLES / 2);
  localparam cnt_t THREE_HALF  = cnt_t'((3 * UNIT_CYCLES) / 2);
  localparam cnt_t LEAD_MIN    = cnt_t'(12 * UNIT_CYCLES);
  localparam cnt_t LEAD_MAX    = cnt_t'(20 * UNIT_CYCLES);
  localparam cnt_t DSPACE_MIN  = cnt_t'(6 * UNIT_CYCLES);
  localparam cnt_t DSPACE_MAX  = cnt_t'(10 * UNIT_CYCLES);
  localparam cnt_t RSPACE_MIN  = cnt_t'(3 * UNIT_CYCLES);
  localparam cnt_t RSPACE_MAX  = cnt_t'(5 * UNIT_CYCLES);
  localparam cnt_t ONE_MIN     = cnt_t'(2 * UNIT_CYCLES);
  localparam cnt_t ONE_MAX     = cnt_t'(4 * UNIT_CYCLES);
  localparam cnt_t TIMEOUT_CNT = cnt_t'(20 * UNIT_CYCLES + 1);
  localparam cnt_t CNT_ONE     = cnt_t'(1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REPEAT_MARK
  } state_t;

  function automatic logic in_range(input cnt_t value, input cnt_t lo, input cnt_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

  logic        sync1_q, sync1_d;
  logic        mark_q, mark_d;
  logic        mark_prev_q, mark_prev_d;
  cnt_t        cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        repeat_q, repeat_d;
  logic        error_q, error_d;

  logic mark_start;
  logic mark_end;
  logic any_edge;
  logic fail;
  logic timeout;

  always_comb begin
    sync1_d     = ~i_ir;
    mark_d      = sync1_q;
    mark_prev_d = mark_q;

    mark_start = mark_q & ~mark_prev_q;
    mark_end   = ~mark_q & mark_prev_q;
    any_edge   = mark_start | mark_end;

    // Counter holds the length of the level that just ended when an edge is seen.
    if (any_edge) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    repeat_d  = 1'b0;
    error_d   = 1'b0;
    fail      = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mark_start) begin
          state_d = LEAD_MARK;
        end
      end
      LEAD_MARK: begin
        if (mark_end) begin
          if (in_range(cnt_q, LEAD_MIN, LEAD_MAX)) begin
            state_d = LEAD_SPACE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      LEAD_SPACE: begin
        if (mark_start) begin
          if (in_range(cnt_q, DSPACE_MIN, DSPACE_MAX)) begin
            state_d   = BIT_MARK;
            bit_idx_d = 5'd0;
          end else if (in_range(cnt_q, RSPACE_MIN, RSPACE_MAX)) begin
            state_d = REPEAT_MARK;
          end else begin
            fail = 1'b1;
          end
        end
      end
      BIT_MARK: begin
        if (mark_end) begin
          if (in_range(cnt_q, HALF_U, THREE_HALF)) begin
            state_d = BIT_SPACE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      BIT_SPACE: begin
        if (mark_start) begin
          if (in_range(cnt_q, HALF_U, THREE_HALF) || in_range(cnt_q, ONE_MIN, ONE_MAX)) begin
            // Shift right so the first bit received lands in bit 0.
            shift_d = {in_range(cnt_q, ONE_MIN, ONE_MAX), shift_q[31:1]};
            if (bit_idx_q == 5'd31) begin
              state_d = STOP_MARK;
            end else begin
              bit_idx_d = bit_idx_q + 5'd1;
              state_d   = BIT_MARK;
            end
          end else begin
            fail = 1'b1;
          end
        end
      end
      STOP_MARK: begin
        if (mark_end) begin
          if (in_range(cnt_q, HALF_U, THREE_HALF)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      REPEAT_MARK: begin
        if (mark_end) begin
          if (in_range(cnt_q, HALF_U, THREE_HALF)) begin
            repeat_d = 1'b1;
            state_d  = IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    timeout = (state_q != IDLE) && !any_edge && (cnt_q == TIMEOUT_CNT);

    // A failing mark start may itself be the lead of the next frame.
    if (fail) begin
      error_d   = 1'b1;
      state_d   = mark_start ? LEAD_MARK : IDLE;
      bit_idx_d = bit_idx_q;
    end else if (timeout) begin
      error_d = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q     <= 1'b0;
      mark_q      <= 1'b0;
      mark_prev_q <= 1'b0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      bit_idx_q   <= 5'd0;
      shift_q     <= 32'd0;
      data_q      <= 32'd0;
      valid_q     <= 1'b0;
      repeat_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      mark_q      <= mark_d;
      mark_prev_q <= mark_prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      repeat_q    <= repeat_d;
      error_q     <= error_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_repeat     = repeat_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_nec_frame_receiver.sv
// Scoreboard bench for nec_frame_receiver: directed IR waveforms push expected
// strobes into a queue that a negedge monitor pops whenever a strobe appears.
module tb_nec_frame_receiver;

  localparam int U = 8;

  localparam int KIND_VALID  = 0;
  localparam int KIND_REPEAT = 1;
  localparam int KIND_ERROR  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_repeat;
  logic        o_error;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          vec_count  = 0;
  int          miss_count = 0;
  int          cyc        = 0;
  int          err_cyc    = 0;
  int          cyc0;
  logic [31:0] model_data = 32'd0;

  nec_frame_receiver #(.UNIT_CYCLES(U), .CNT_WIDTH(20)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ir        (ir),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .o_repeat    (o_repeat),
    .o_error     (o_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_count++;
    if (act !== req) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Drive a level for a number of clock cycles; mark = carrier = i_ir low.
  task automatic applyStimulus(input logic mark, input int cycles);
    ir = ~mark;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pushExpect(input int kind, input logic [31:0] data);
    exp_t e;
    if (kind == KIND_VALID) model_data = data;
    e.kind = kind;
    e.data = (kind == KIND_VALID) ? data : model_data;
    exp_q.push_back(e);
  endtask

  task automatic sendLead(input int lead_u, input int space_u);
    applyStimulus(1'b1, lead_u * U);
    applyStimulus(1'b0, space_u * U);
  endtask

  task automatic sendBits(input logic [31:0] d, input int nbits, input int one_u);
    for (int i = 0; i < nbits; i++) begin
      applyStimulus(1'b1, U);
      applyStimulus(1'b0, d[i] ? one_u * U : U);
    end
  endtask

  task automatic sendFrame(input logic [31:0] d, input int lead_u, input int one_u);
    sendLead(lead_u, 8);
    sendBits(d, 32, one_u);
    applyStimulus(1'b1, U);
    applyStimulus(1'b0, 30 * U);
  endtask

  task automatic endScenario(input string name);
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (!rst && (o_data_valid || o_repeat || o_error)) begin
        kind = o_data_valid ? KIND_VALID : (o_repeat ? KIND_REPEAT : KIND_ERROR);
        if (o_error) err_cyc = cyc;
        checkOutput("strobe_onehot", 32'($countones({o_data_valid, o_repeat, o_error})), 32'd1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe_kind", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("strobe_kind", 32'(kind), 32'(e.kind));
          checkOutput("o_data", o_data, e.data);
        end
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no completion, required completion within 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ir  = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("reset_o_data", o_data, 32'd0);
    checkOutput("reset_strobes", {29'd0, o_data_valid, o_repeat, o_error}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4 * U);

    $display("[TB] basic frame 0xBA45FF00");
    pushExpect(KIND_VALID, 32'hBA45FF00);
    sendFrame(32'hBA45FF00, 16, 3);
    endScenario("basic_frame_pending");

    $display("[TB] repeat code");
    pushExpect(KIND_REPEAT, 32'd0);
    sendLead(16, 4);
    applyStimulus(1'b1, U);
    applyStimulus(1'b0, 30 * U);
    endScenario("repeat_pending");
    checkOutput("o_data_after_repeat", o_data, 32'hBA45FF00);

    $display("[TB] bad bit-5 space then frame 0xEE11FE01");
    pushExpect(KIND_ERROR, 32'd0);
    pushExpect(KIND_VALID, 32'hEE11FE01);
    sendLead(16, 8);
    sendBits(32'h0000_0015, 5, 3);
    applyStimulus(1'b1, U);
    applyStimulus(1'b0, 6 * U);
    sendFrame(32'hEE11FE01, 16, 3);
    endScenario("bad_space_pending");

    $display("[TB] held mark timeout");
    pushExpect(KIND_ERROR, 32'd0);
    cyc0 = cyc;
    applyStimulus(1'b1, 25 * U);
    applyStimulus(1'b0, 30 * U);
    endScenario("timeout_pending");
    checkOutput("timeout_latency", 32'(err_cyc - cyc0), 32'(20 * U + 4));

    $display("[TB] reset mid-frame then frame 0xF708FB04");
    sendLead(16, 8);
    sendBits(32'hF708FB04, 16, 3);
    rst = 1'b1;
    model_data = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("o_data_after_reset", o_data, 32'd0);
    applyStimulus(1'b0, 10 * U);
    pushExpect(KIND_VALID, 32'hF708FB04);
    sendFrame(32'hF708FB04, 16, 3);
    endScenario("reset_frame_pending");

    $display("[TB] boundary lead 12U with 2U ones, lead 20U with 4U ones");
    pushExpect(KIND_VALID, 32'hE31C7F80);
    sendFrame(32'hE31C7F80, 12, 2);
    pushExpect(KIND_VALID, 32'h6996A55A);
    sendFrame(32'h6996A55A, 20, 4);
    endScenario("boundary_pending");

    $display("[TB] short 11U lead");
    pushExpect(KIND_ERROR, 32'd0);
    applyStimulus(1'b1, 11 * U);
    applyStimulus(1'b0, 30 * U);
    endScenario("short_lead_pending");

    $display("[TB] 5U bit space then frame 0x9A65F50A");
    pushExpect(KIND_ERROR, 32'd0);
    pushExpect(KIND_VALID, 32'h9A65F50A);
    sendLead(16, 8);
    sendBits(32'h0000_0005, 3, 3);
    applyStimulus(1'b1, U);
    applyStimulus(1'b0, 5 * U);
    sendFrame(32'h9A65F50A, 16, 3);
    endScenario("long_space_pending");

    checkOutput("final_o_data", o_data, 32'h9A65F50A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
